// File: rtl/wb_shift_out_if.sv
// Wishbone write-only bus bundle for wb_shift_out.
// master drives cyc/stb/data, slave returns ack/stall.
interface wb_shift_out_if #(
  parameter int DATA_WIDTH = 8
) ();

  logic                  cyc;
  logic                  stb;
  logic [DATA_WIDTH-1:0] data;
  logic                  ack;
  logic                  stall;

  modport master (
    output cyc,
    output stb,
    output data,
    input  ack,
    input  stall
  );

  modport slave (
    input  cyc,
    input  stb,
    input  data,
    output ack,
    output stall
  );

endinterface

// File: rtl/wb_shift_out.sv
// Wishbone word serialiser for 74HC164/74HC595 daisy chains.
// Ports: i_clk, i_reset_n (sync, active-low), wb (slave: cyc/stb/data in,
//   ack/stall out), o_busy, o_shifter_ds/cp/mr_n; o_latch when the
//   HC595_LATCH_EN macro is defined (storage-register pulse after a word).
module wb_shift_out #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLK_DIV_RATE = 1,
  parameter int MSB_FIRST    = 0
) (
  input  logic         i_clk,
  input  logic         i_reset_n,
  wb_shift_out_if.slave wb,
  output logic         o_busy,
  output logic         o_shifter_ds,
  output logic         o_shifter_cp,
  output logic         o_shifter_mr_n
`ifdef HC595_LATCH_EN
  ,
  output logic         o_latch
`endif
);

  localparam int CW = $clog2(CLK_DIV_RATE + 1);
  localparam int IW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLK_DIV_RATE - 1);
  localparam logic [IW-1:0] BIT_LAST = IW'(DATA_WIDTH - 1);
  localparam bit MSB = (MSB_FIRST != 0);

`ifdef HC595_LATCH_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLK_LOW  = 2'd1,
    CLK_HIGH = 2'd2,
    LATCH    = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CLK_LOW  = 2'd1,
    CLK_HIGH = 2'd2
  } state_t;
`endif

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [IW-1:0]         bit_idx;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic [DATA_WIDTH-1:0] hold_data;
  logic                  hold_full;
  logic                  ack;
  logic                  ds;
  logic                  cp;
`ifdef HC595_LATCH_EN
  logic                  latch;
`endif

  logic                  accept;
  logic                  phase_end;
  logic                  last_bit;
  logic                  start_word;
  logic                  first_bit;
  logic                  next_bit;
  logic [DATA_WIDTH-1:0] shifted;

  assign accept    = wb.cyc && wb.stb && !hold_full;
  assign phase_end = (cnt == CNT_LAST);
  assign last_bit  = (bit_idx == BIT_LAST);

  assign first_bit = MSB ? hold_data[DATA_WIDTH-1] : hold_data[0];
  assign next_bit  = MSB ? shift_reg[DATA_WIDTH-2] : shift_reg[1];
  assign shifted   = MSB ? {shift_reg[DATA_WIDTH-2:0], 1'b0}
                         : {1'b0, shift_reg[DATA_WIDTH-1:1]};

  // A word is started from idle, or straight off the end of the
  // previous word so streamed words have no gap between them.
  always_comb begin
    start_word = 1'b0;
    case (state)
      IDLE:     start_word = hold_full;
`ifdef HC595_LATCH_EN
      LATCH:    start_word = phase_end && hold_full;
`else
      CLK_HIGH: start_word = phase_end && last_bit && hold_full;
`endif
      default:  start_word = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      hold_data <= '0;
      hold_full <= 1'b0;
      ack       <= 1'b0;
      ds        <= 1'b0;
      cp        <= 1'b0;
`ifdef HC595_LATCH_EN
      latch     <= 1'b0;
`endif
    end else begin
      ack <= accept;
      if (accept) begin
        hold_full <= 1'b1;
        hold_data <= wb.data;
      end
      if (start_word) begin
        state     <= CLK_LOW;
        shift_reg <= hold_data;
        ds        <= first_bit;
        cp        <= 1'b0;
        cnt       <= '0;
        bit_idx   <= '0;
        hold_full <= 1'b0;
`ifdef HC595_LATCH_EN
        latch     <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            cp  <= 1'b0;
            ds  <= 1'b0;
            cnt <= '0;
          end
          CLK_LOW: begin
            if (phase_end) begin
              state <= CLK_HIGH;
              cp    <= 1'b1;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          CLK_HIGH: begin
            if (phase_end) begin
              cp  <= 1'b0;
              cnt <= '0;
              if (!last_bit) begin
                state     <= CLK_LOW;
                shift_reg <= shifted;
                ds        <= next_bit;
                bit_idx   <= bit_idx + 1'b1;
              end else begin
                ds <= 1'b0;
`ifdef HC595_LATCH_EN
                state <= LATCH;
                latch <= 1'b1;
`else
                state <= IDLE;
`endif
              end
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef HC595_LATCH_EN
          LATCH: begin
            if (phase_end) begin
              state <= IDLE;
              latch <= 1'b0;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          default: begin
            state <= IDLE;
            cp    <= 1'b0;
            ds    <= 1'b0;
            cnt   <= '0;
`ifdef HC595_LATCH_EN
            latch <= 1'b0;
`endif
          end
        endcase
      end
    end
  end

  assign wb.ack         = ack;
  assign wb.stall       = hold_full;
  assign o_busy         = (state != IDLE) || hold_full;
  assign o_shifter_ds   = ds;
  assign o_shifter_cp   = cp;
  // Chain clears for as long as reset is held.
  assign o_shifter_mr_n = i_reset_n;
`ifdef HC595_LATCH_EN
  assign o_latch        = latch;
`endif

endmodule

// File: tb/tb_wb_shift_out.sv
// Bench for wb_shift_out: two instances (8b/div2/LSB, 16b/div1/MSB)
// checked every cycle against a word-timeline model.
module tb_wb_shift_out;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  wb_shift_out_if #(.DATA_WIDTH(8))  bus_a ();
  wb_shift_out_if #(.DATA_WIDTH(16)) bus_b ();

  logic busy_a, ds_a, cp_a, mr_a, latch_a;
  logic busy_b, ds_b, cp_b, mr_b, latch_b;

`ifdef HC595_LATCH_EN
  localparam bit HAS_LATCH = 1'b1;
`else
  localparam bit HAS_LATCH = 1'b0;
  assign latch_a = 1'b0;
  assign latch_b = 1'b0;
`endif

  wb_shift_out #(
    .DATA_WIDTH(8), .CLK_DIV_RATE(2), .MSB_FIRST(0)
  ) u_dut_a (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .wb(bus_a),
    .o_busy(busy_a),
    .o_shifter_ds(ds_a),
    .o_shifter_cp(cp_a),
    .o_shifter_mr_n(mr_a)
`ifdef HC595_LATCH_EN
    ,
    .o_latch(latch_a)
`endif
  );

  wb_shift_out #(
    .DATA_WIDTH(16), .CLK_DIV_RATE(1), .MSB_FIRST(1)
  ) u_dut_b (
    .i_clk(clk),
    .i_reset_n(rst_n),
    .wb(bus_b),
    .o_busy(busy_b),
    .o_shifter_ds(ds_b),
    .o_shifter_cp(cp_b),
    .o_shifter_mr_n(mr_b)
`ifdef HC595_LATCH_EN
    ,
    .o_latch(latch_b)
`endif
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int pw(int id);
    return (id == 0) ? 8 : 16;
  endfunction
  function automatic int pd(int id);
    return (id == 0) ? 2 : 1;
  endfunction
  function automatic bit pm(int id);
    return id != 0;
  endfunction
  function automatic int wt(int id);
    return pw(id) * 2 * pd(id) + (HAS_LATCH ? pd(id) : 0);
  endfunction

  // Model: a word occupies [m_start, m_end]; outputs follow from offset.
  int          cyc_n = 0;
  int          m_start [2] = '{0, 0};
  int          m_end   [2] = '{-1, -1};
  bit          m_hold  [2] = '{0, 0};
  bit          m_ack   [2] = '{0, 0};
  logic [15:0] m_hw    [2] = '{16'h0, 16'h0};
  logic [15:0] m_word  [2] = '{16'h0, 16'h0};
  bit          m_acc, m_ld;
  bit          p_rst = 1'b0;
  bit          p_cyc [2] = '{0, 0};
  bit          p_stb [2] = '{0, 0};
  logic [15:0] p_dat [2] = '{16'h0, 16'h0};

  function automatic bit e_active(int id, int c);
    return (c >= m_start[id]) && (c <= m_end[id]);
  endfunction

  // {latch, cp, ds}
  function automatic logic [2:0] e_out(int id, int c);
    int o, b, w, d;
    w = pw(id);
    d = pd(id);
    if (!e_active(id, c)) return 3'b000;
    o = c - m_start[id];
    b = o / (2 * d);
    if (b >= w) return 3'b100;
    return {1'b0, (o % (2 * d)) >= d, m_word[id][pm(id) ? w - 1 - b : b]};
  endfunction

  bit   rq_a[$];
  bit   rq_b[$];
  int   hi_a, hi_b, bz_a, bz_b, ak_a, ak_b, lt_a;
  logic pcp_a = 1'b0;
  logic pcp_b = 1'b0;

  always @(negedge clk) begin
    logic [5:0] g;
    logic [2:0] e;
    cyc_n++;
    for (int id = 0; id < 2; id++) begin
      if (!p_rst) begin
        m_hold[id] = 1'b0;
        m_ack[id]  = 1'b0;
        m_end[id]  = -1;
      end else begin
        m_acc = p_cyc[id] && p_stb[id] && !m_hold[id];
        m_ld  = m_hold[id] && (cyc_n - 1 >= m_end[id]);
        m_ack[id] = m_acc;
        if (m_ld) begin
          m_word[id]  = m_hw[id];
          m_start[id] = cyc_n;
          m_end[id]   = cyc_n + wt(id) - 1;
          m_hold[id]  = 1'b0;
        end
        if (m_acc) begin
          m_hold[id] = 1'b1;
          m_hw[id]   = p_dat[id];
        end
      end
      if (cyc_n > 2) begin
        if (id == 0) g = {bus_a.ack, bus_a.stall, busy_a, latch_a, cp_a, ds_a};
        else         g = {bus_b.ack, bus_b.stall, busy_b, latch_b, cp_b, ds_b};
        e = e_out(id, cyc_n);
        chk($sformatf("ack%0d@%0d", id, cyc_n), g[5], m_ack[id]);
        chk($sformatf("stall%0d@%0d", id, cyc_n), g[4], m_hold[id]);
        chk($sformatf("busy%0d@%0d", id, cyc_n), g[3],
            m_hold[id] || e_active(id, cyc_n));
        chk($sformatf("latch%0d@%0d", id, cyc_n), g[2], e[2]);
        chk($sformatf("cp%0d@%0d", id, cyc_n), g[1], e[1]);
        chk($sformatf("ds%0d@%0d", id, cyc_n), g[0], e[0]);
        chk($sformatf("mr%0d@%0d", id, cyc_n),
            (id == 0) ? mr_a : mr_b, rst_n);
      end
    end
    if (cp_a && !pcp_a) rq_a.push_back(ds_a);
    if (cp_b && !pcp_b) rq_b.push_back(ds_b);
    pcp_a = cp_a;
    pcp_b = cp_b;
    hi_a += int'(cp_a);
    hi_b += int'(cp_b);
    bz_a += int'(busy_a);
    bz_b += int'(busy_b);
    ak_a += int'(bus_a.ack);
    ak_b += int'(bus_b.ack);
    lt_a += int'(latch_a);
    p_rst    = rst_n;
    p_cyc[0] = bus_a.cyc;
    p_stb[0] = bus_a.stb;
    p_dat[0] = {8'h00, bus_a.data};
    p_cyc[1] = bus_b.cyc;
    p_stb[1] = bus_b.stb;
    p_dat[1] = bus_b.data;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clr();
    rq_a.delete();
    rq_b.delete();
    hi_a = 0; hi_b = 0; bz_a = 0; bz_b = 0;
    ak_a = 0; ak_b = 0; lt_a = 0;
  endtask

  task automatic wr(input int id, input logic [15:0] d);
    bit got;
    got = 1'b0;
    if (id == 0) begin
      bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.data = d[7:0];
    end else begin
      bus_b.cyc = 1'b1; bus_b.stb = 1'b1; bus_b.data = d;
    end
    for (int i = 0; i < 300; i++) begin
      step(1);
      if ((id == 0) ? bus_a.ack : bus_b.ack) begin
        got = 1'b1;
        break;
      end
    end
    if (id == 0) begin
      bus_a.cyc = 1'b0; bus_a.stb = 1'b0;
    end else begin
      bus_b.cyc = 1'b0; bus_b.stb = 1'b0;
    end
    if (!got) chk($sformatf("wr_timeout%0d", id), 32'd0, 32'd1);
  endtask

  task automatic wait_idle(input int id);
    for (int i = 0; i < 600; i++) begin
      if (!((id == 0) ? busy_a : busy_b)) break;
      step(1);
    end
    chk($sformatf("idle_timeout%0d", id), (id == 0) ? busy_a : busy_b, 1'b0);
  endtask

  task automatic rnd_thread(input int id);
    logic [15:0] d;
    for (int k = 0; k < 30; k++) begin
      step($urandom_range(0, 40) * int'($urandom_range(0, 2) != 0));
      if ($urandom_range(0, 3) == 0) begin
        if (id == 0) begin
          bus_a.cyc = 1'b0; bus_a.stb = 1'b1; bus_a.data = 8'($urandom);
        end else begin
          bus_b.cyc = 1'b1; bus_b.stb = 1'b0; bus_b.data = 16'($urandom);
        end
        step(1);
      end
      d = 16'($urandom);
      wr(id, d);
    end
  endtask

  int a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  logic [15:0] two_w;

  initial begin
    bus_a.cyc = 1'b0; bus_a.stb = 1'b0; bus_a.data = '0;
    bus_b.cyc = 1'b0; bus_b.stb = 1'b0; bus_b.data = '0;
    rst_n = 1'b0;
    step(3);
    chk("rst_cp", cp_a, 1'b0);
    chk("rst_ds", ds_a, 1'b0);
    chk("rst_ack", bus_a.ack, 1'b0);
    chk("rst_stall", bus_a.stall, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_mr", mr_a, 1'b0);
    rst_n = 1'b1;
    step(2);

    // single word 0xA5
    clr();
    wr(0, 16'h00A5);
    wait_idle(0);
    step(3);
    chk("a5_ack", ak_a, 1);
    chk("a5_pulses", rq_a.size(), 8);
    for (int i = 0; i < 8 && i < rq_a.size(); i++)
      chk($sformatf("a5_bit%0d", i), rq_a[i], a5[i]);
    chk("a5_hi", hi_a, 16);
    chk("a5_busy", bz_a, 1 + wt(0));
    chk("a5_cp_end", cp_a, 1'b0);
    chk("a5_ds_end", ds_a, 1'b0);
    if (HAS_LATCH) chk("a5_latch", lt_a, 2);
    else chk("a5_latch", lt_a, 0);

    // back-to-back 0x0F, 0xF0, plus an stb while stalled
    clr();
    wr(0, 16'h000F);
    wr(0, 16'h00F0);
    chk("b2b_stall", bus_a.stall, 1'b1);
    bus_a.cyc = 1'b1; bus_a.stb = 1'b1; bus_a.data = 8'h55;
    step(6);
    bus_a.cyc = 1'b0; bus_a.stb = 1'b0;
    wait_idle(0);
    step(3);
    chk("b2b_ack", ak_a, 2);
    chk("b2b_pulses", rq_a.size(), 16);
    two_w = 16'hF00F;
    for (int i = 0; i < 16 && i < rq_a.size(); i++)
      chk($sformatf("b2b_bit%0d", i), rq_a[i], two_w[i]);
    chk("b2b_busy", bz_a, 1 + 2 * wt(0));

    // 16-bit MSB-first 0x8001
    clr();
    wr(1, 16'h8001);
    wait_idle(1);
    step(3);
    chk("w16_pulses", rq_b.size(), 16);
    for (int i = 0; i < 16 && i < rq_b.size(); i++)
      chk($sformatf("w16_bit%0d", i), rq_b[i], (i == 0 || i == 15));
    chk("w16_hi", hi_b, 16);
    chk("w16_busy", bz_b, 1 + wt(1));
    chk("w16_ack", ak_b, 1);

    // reset during bit 3 of 0xFF with the holding register full
    wr(0, 16'h00FF);
    wr(0, 16'h0012);
    step(12);
    chk("mid_stall", bus_a.stall, 1'b1);
    rst_n = 1'b0;
    chk("mid_mr", mr_a, 1'b0);
    step(1);
    chk("mid_cp", cp_a, 1'b0);
    chk("mid_ds", ds_a, 1'b0);
    chk("mid_stall0", bus_a.stall, 1'b0);
    chk("mid_busy", busy_a, 1'b0);
    rst_n = 1'b1;
    clr();
    step(60);
    chk("mid_no_cp", rq_a.size(), 0);
    chk("mid_no_busy", bz_a, 0);

    // stb without cyc
    clr();
    bus_a.cyc = 1'b0; bus_a.stb = 1'b1; bus_a.data = 8'h00;
    step(10);
    bus_a.stb = 1'b0;
    step(3);
    chk("nocyc_ack", ak_a, 0);
    chk("nocyc_cp", rq_a.size(), 0);
    chk("nocyc_busy", bz_a, 0);

    fork
      rnd_thread(0);
      rnd_thread(1);
    join
    wait_idle(0);
    wait_idle(1);
    step(5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/wb_shift_out.md
Name: wb_shift_out

Overview:
- Parametrised successor of the single-byte 74HC164 Wishbone driver.
- Serialises a DATA_WIDTH-bit word into a chain of serial-in shift registers (74HC164/74HC595 daisy chains driving multi-digit displays).
- Configurable bit order and clock divider.
- One-word holding buffer, so back-to-back writes stream with no inter-word gap.

Parameters:
- DATA_WIDTH, 8, bits per word (>=2; 8*N for N chained devices).
- CLK_DIV_RATE, 1, i_clk cycles per shift-clock phase (>=1); one bit = 2*CLK_DIV_RATE cycles.
- MSB_FIRST, 0, 1 = shift bit DATA_WIDTH-1 first, 0 = bit 0 first.

Ports:
- i_clk  in  1  clock.
- i_reset_n  in  1  synchronous, active-low reset.
- i_wb_cyc  in  1  Wishbone cycle.
- i_wb_stb  in  1  Wishbone strobe.
- i_wb_data  in  DATA_WIDTH  word to shift out.
- o_wb_ack  out  1  one-cycle ack of an accepted write.
- o_wb_stall  out  1  holding buffer full.
- o_busy  out  1  shifting in progress or word pending.
- o_shifter_ds  out  1  serial data.
- o_shifter_cp  out  1  shift clock; device samples on rising edge.
- o_shifter_mr_n  out  1  device master reset, active low.

Behaviour:
- Reset values: reset i_reset_n, synchronous, active-low; clock i_clk. While reset is low, ack=0, stall=0, busy=0, ds=0, cp=0, holding buffer empty, state IDLE, divider counter 0.
- o_shifter_mr_n = i_reset_n, combinational, so the chain clears while reset is held.
- Accept: i_wb_cyc && i_wb_stb && !o_wb_stall in cycle T.
  - Data is latched into the holding register at T+1.
  - o_wb_ack=1 for exactly T+1.
  - o_wb_stall is registered: 1 from T+1 while the holding register is full.
- Consume: the holding register transfers to the shift register when the FSM starts a word. The holding register is empty the next cycle; stall drops that cycle.
- Accept and consume never coincide: accept requires empty, consume requires full.
- FSM states: IDLE, CLK_LOW, CLK_HIGH. A phase counter (width $clog2(CLK_DIV_RATE+1)) counts CLK_DIV_RATE cycles per phase.
  - IDLE, holding full -> CLK_LOW next cycle. Shift reg loaded, bit index = 0, ds = first bit, cp=0.
  - CLK_LOW, phase expires -> CLK_HIGH, cp=1, ds held.
  - CLK_HIGH, phase expires, bits remain -> CLK_LOW, cp=0, shift reg advances one bit, ds = next bit.
  - CLK_HIGH, phase expires, last bit:
    - holding full -> CLK_LOW with the next word loaded (no gap).
    - otherwise -> IDLE, cp=0, ds=0.
- Latency: a write accepted at T drives the first ds at T+2. First cp rise at T+2+CLK_DIV_RATE. A word occupies 2*CLK_DIV_RATE*DATA_WIDTH cycles.
- Bit order:
  - MSB_FIRST=0: ds = shift_reg[0], shift right.
  - MSB_FIRST=1: ds = shift_reg[DATA_WIDTH-1], shift left.
- ds changes only on the cp falling transition or on word load; it is stable for the whole high phase.
- o_busy = (state != IDLE) || holding full.
- Illegal state encodings -> IDLE next cycle.
- Reset mid-word: next cycle all outputs are at reset values and the pending word is discarded. No partial word resumes after reset.
- i_wb_stb while stalled: ignored, no ack.

Optional Feature:
- Macro HC595_LATCH_EN.
- Defined:
  - Adds port o_latch (out, 1, storage-register clock).
  - Adds state LATCH after the last CLK_HIGH: cp=0, ds=0, o_latch=1 for CLK_DIV_RATE cycles, then to CLK_LOW (holding full) or IDLE.
  - Word time grows by CLK_DIV_RATE cycles.
  - o_latch resets to 0.
- Undefined: no o_latch port and no LATCH state; timing as above.

Test Plan:
- DATA_WIDTH=8, CLK_DIV_RATE=2, MSB_FIRST=0, write 0xA5 at T -> ack at T+1 only; ds sequence at cp rises 1,0,1,0,0,1,0,1; 8 cp pulses, each 2 cycles high; busy T+1..T+33; cp=0 and ds=0 afterwards.
- Same config, write 0x0F then 0xF0 immediately after stall drops -> second ack during the first word; stall high until 0x0F loads; a third stb during stall gets no ack; 16 bits with no idle cycle between words.
- DATA_WIDTH=16, MSB_FIRST=1, CLK_DIV_RATE=1, write 0x8001 -> ds 1, then fourteen 0s, then 1; 16 cp pulses; word lasts 32 cycles.
- Reset low for 1 cycle during bit 3 of 0xFF with holding full -> cp=0, ds=0, mr_n=0, stall=0, busy=0; no further cp pulses without a new write.
- With HC595_LATCH_EN, CLK_DIV_RATE=2, write 0x3C -> o_latch high for exactly 2 cycles immediately after the 8th cp high phase, cp=0 throughout; o_latch never high otherwise.
- Write 0x00 with cyc=0, stb=1 -> no ack, no cp activity, busy stays 0.
